// File: rtl/bp_be_dcache_mem_responder_if.sv
// Memory command/response channel between the D$ harness (master) and the
// memory responder (slave). Message layout, LSB first:
//   msg_type[3:0], addr[paddr-1:0], size[2:0], payload[15:0], data[block-1:0]
interface bp_be_dcache_mem_responder_if
  #(parameter int msg_width_p = 575)
  ();

  logic [msg_width_p-1:0] mem_cmd;
  logic                   mem_cmd_v;
  logic                   mem_cmd_ready;
  logic [msg_width_p-1:0] mem_resp;
  logic                   mem_resp_v;
  logic                   mem_resp_yumi;

  modport master
    (output mem_cmd, mem_cmd_v, mem_resp_yumi
    ,input  mem_cmd_ready, mem_resp, mem_resp_v
    );

  modport slave
    (input  mem_cmd, mem_cmd_v, mem_resp_yumi
    ,output mem_cmd_ready, mem_resp, mem_resp_v
    );

endinterface

// File: rtl/bp_be_dcache_mem_responder.sv
// Memory-side responder for the D$ test harness. Services one cce_mem_msg at a
// time against a block-organized backing store and returns one response per
// command after delay_p cycles.
// Optional feature: define BP_MEM_RESPONDER_RAND_DELAY_EN to add a per-command
// 0..7 cycle extra latency drawn from an 8-bit LFSR.
// The backing store has no reset; its power-up contents come from the
// simulator (zero in two-state simulation).
module bp_be_dcache_mem_responder
  #(parameter int paddr_width_p     = 40
   ,parameter int cce_block_width_p = 512
   ,parameter int mem_els_p         = 64
   ,parameter int delay_p           = 4
   )
  (input  logic clk_i
  ,input  logic reset_i
  ,bp_be_dcache_mem_responder_if.slave mem_if
  );

  // Message layout
  localparam int msg_type_width_lp    = 4;
  localparam int size_width_lp        = 3;
  localparam int payload_width_lp     = 16;
  localparam int header_width_lp      = msg_type_width_lp + paddr_width_p + size_width_lp + payload_width_lp;
  localparam int cce_mem_msg_width_lp = header_width_lp + cce_block_width_p;
  localparam int addr_lsb_lp          = msg_type_width_lp;
  localparam int size_lsb_lp          = addr_lsb_lp + paddr_width_p;

  // Store geometry
  localparam int block_bytes_lp  = cce_block_width_p / 8;
  localparam int block_offset_lp = $clog2(block_bytes_lp);
  localparam int idx_width_lp    = $clog2(mem_els_p);
  localparam int cnt_width_lp    = $clog2(delay_p + 8);

  localparam logic [3:0] e_cce_mem_rd    = 4'd0;
  localparam logic [3:0] e_cce_mem_wb    = 4'd1;
  localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_wait  = 2'd1,
    e_resp  = 2'd2
  } state_e;

  state_e state_r, state_n;
  logic [cnt_width_lp-1:0]         cnt_r, cnt_n, load_cnt_s;
  logic [cce_mem_msg_width_lp-1:0] resp_r;
  logic [cce_block_width_p-1:0]    mem_r [mem_els_p];

  logic                         ready_s, cmd_accept_s;
  logic [header_width_lp-1:0]   cmd_header_s;
  logic [3:0]                   cmd_type_s;
  logic [2:0]                   cmd_size_s, size_clamp_s;
  logic [idx_width_lp-1:0]      blk_idx_s;
  logic [block_offset_lp-1:0]   byte_off_s;
  logic [cce_block_width_p-1:0] cmd_data_s, blk_rd_s, resp_data_s, wr_data_s;
  logic [block_bytes_lp-1:0]    wr_mask_s;
  logic [7:0]                   byte_en_s;
  logic [63:0]                  lane_mask_s, uc_rd_data_s;
  logic                         wb_en_s, uc_wr_en_s;

  // Command field extraction; address bits above the store index are ignored
  assign cmd_header_s = mem_if.mem_cmd[header_width_lp-1:0];
  assign cmd_type_s   = mem_if.mem_cmd[msg_type_width_lp-1:0];
  assign cmd_size_s   = mem_if.mem_cmd[size_lsb_lp +: size_width_lp];
  assign blk_idx_s    = mem_if.mem_cmd[addr_lsb_lp + block_offset_lp +: idx_width_lp];
  assign byte_off_s   = mem_if.mem_cmd[addr_lsb_lp +: block_offset_lp];
  assign cmd_data_s   = mem_if.mem_cmd[header_width_lp +: cce_block_width_p];

  // Ready is suppressed while reset is asserted so nothing is accepted then
  assign ready_s      = (state_r == e_ready) & ~reset_i;
  assign cmd_accept_s = mem_if.mem_cmd_v & ready_s;

  assign mem_if.mem_cmd_ready = ready_s;
  assign mem_if.mem_resp_v    = (state_r == e_resp);
  assign mem_if.mem_resp      = resp_r;

  // Uncached accesses: sizes above 8 bytes are clamped to 8
  assign size_clamp_s = (cmd_size_s > 3'd3) ? 3'd3 : cmd_size_s;

  // Byte enable and data lane mask for the clamped uncached size
  always_comb begin
    byte_en_s   = 8'hFF;
    lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
    case (size_clamp_s)
      3'd0: begin byte_en_s = 8'h01; lane_mask_s = 64'h0000_0000_0000_00FF; end
      3'd1: begin byte_en_s = 8'h03; lane_mask_s = 64'h0000_0000_0000_FFFF; end
      3'd2: begin byte_en_s = 8'h0F; lane_mask_s = 64'h0000_0000_FFFF_FFFF; end
      default: begin byte_en_s = 8'hFF; lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF; end
    endcase
  end

  assign blk_rd_s     = mem_r[blk_idx_s];
  assign uc_rd_data_s = 64'(blk_rd_s >> {byte_off_s, 3'b000}) & lane_mask_s;
  assign wr_data_s    = cce_block_width_p'(cmd_data_s[63:0]) << {byte_off_s, 3'b000};
  assign wr_mask_s    = block_bytes_lp'(byte_en_s) << byte_off_s;

  // Message-type decode: response data and write enables
  always_comb begin
    resp_data_s = {cce_block_width_p{1'b0}};
    wb_en_s     = 1'b0;
    uc_wr_en_s  = 1'b0;
    case (cmd_type_s)
      e_cce_mem_rd:    resp_data_s = blk_rd_s;
      e_cce_mem_uc_rd: resp_data_s = cce_block_width_p'(uc_rd_data_s);
      e_cce_mem_wb:    wb_en_s     = cmd_accept_s;
      e_cce_mem_uc_wr: uc_wr_en_s  = cmd_accept_s;
      default:         resp_data_s = {cce_block_width_p{1'b0}};
    endcase
  end

`ifdef BP_MEM_RESPONDER_RAND_DELAY_EN
  logic [7:0] lfsr_r, lfsr_n_s;

  // x^8+x^6+x^5+x^4+1 Fibonacci step
  assign lfsr_n_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};

  // Advance the LFSR once per accepted command
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_r <= 8'h01;
    end else if (cmd_accept_s) begin
      lfsr_r <= lfsr_n_s;
    end
  end

  assign load_cnt_s = cnt_width_lp'(delay_p) + cnt_width_lp'(lfsr_n_s[2:0]);
`else
  assign load_cnt_s = cnt_width_lp'(delay_p);
`endif

  // Commit writes in the accept cycle; storage is left untouched by reset
  always_ff @(posedge clk_i) begin
    if (wb_en_s) begin
      mem_r[blk_idx_s] <= cmd_data_s;
    end else if (uc_wr_en_s) begin
      for (int b = 0; b < block_bytes_lp; b++) begin
        if (wr_mask_s[b]) begin
          mem_r[blk_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  // Next-state and latency counter logic
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      e_ready: begin
        if (cmd_accept_s) begin
          cnt_n   = load_cnt_s;
          state_n = (load_cnt_s != {cnt_width_lp{1'b0}}) ? e_wait : e_resp;
        end else begin
          state_n = e_ready;
        end
      end
      e_wait: begin
        cnt_n = cnt_r - {{(cnt_width_lp-1){1'b0}}, 1'b1};
        if (cnt_r == {{(cnt_width_lp-1){1'b0}}, 1'b1}) begin
          state_n = e_resp;
        end else begin
          state_n = e_wait;
        end
      end
      e_resp: begin
        if (mem_if.mem_resp_yumi) begin
          state_n = e_ready;
        end else begin
          state_n = e_resp;
        end
      end
      default: begin
        state_n = e_ready;
        cnt_n   = {cnt_width_lp{1'b0}};
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      cnt_r   <= {cnt_width_lp{1'b0}};
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Response register: captured at accept, held stable until the next accept
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_r <= {cce_mem_msg_width_lp{1'b0}};
    end else if (cmd_accept_s) begin
      resp_r <= {resp_data_s, cmd_header_s};
    end
  end

endmodule

// File: tb/tb_bp_be_dcache_mem_responder.sv
// Directed bench for bp_be_dcache_mem_responder: a delay_p=4 instance runs the
// main sequence and a delay_p=0 instance covers the zero-latency build.
module tb_bp_be_dcache_mem_responder;

  localparam int BW = 512;
  localparam int MW = 575;

  localparam logic [3:0] T_RD    = 4'd0;
  localparam logic [3:0] T_WB    = 4'd1;
  localparam logic [3:0] T_UC_RD = 4'd2;
  localparam logic [3:0] T_UC_WR = 4'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic [MW-1:0] cmd_tb = '0;
  logic cmd_v_tb = 1'b0;
  logic yumi_tb = 1'b0;

  int tests = 0;
  int failed = 0;
  logic [MW-1:0] sb_q [$];

  always #5 clk = ~clk;

  bp_be_dcache_mem_responder_if #(.msg_width_p(MW)) if4 ();
  bp_be_dcache_mem_responder_if #(.msg_width_p(MW)) if0 ();

  assign if4.mem_cmd       = cmd_tb;
  assign if4.mem_cmd_v     = cmd_v_tb & ~sel;
  assign if4.mem_resp_yumi = yumi_tb & ~sel;
  assign if0.mem_cmd       = cmd_tb;
  assign if0.mem_cmd_v     = cmd_v_tb & sel;
  assign if0.mem_resp_yumi = yumi_tb & sel;

  logic          ready_w, resp_v_w;
  logic [MW-1:0] resp_w;
  assign ready_w  = sel ? if0.mem_cmd_ready : if4.mem_cmd_ready;
  assign resp_v_w = sel ? if0.mem_resp_v    : if4.mem_resp_v;
  assign resp_w   = sel ? if0.mem_resp      : if4.mem_resp;

  bp_be_dcache_mem_responder #(.delay_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .mem_if(if4));
  bp_be_dcache_mem_responder #(.delay_p(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .mem_if(if0));

  function automatic logic [MW-1:0] mk(input logic [3:0] t, input logic [39:0] a,
                                       input logic [2:0] s, input logic [15:0] p,
                                       input logic [BW-1:0] d);
    return {d, p, s, a, t};
  endfunction

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, check its latency and response, optionally hold yumi off
  task automatic txn(input string tag, input logic [MW-1:0] cmd, input logic [MW-1:0] exp,
                     input int lat, input int hold);
    int n;
    logic [MW-1:0] held, e;
    @(negedge clk);
    n = 0;
    while (!ready_w && n < 20) begin @(negedge clk); n++; end
    check({tag, "_ready"}, MW'(ready_w), MW'(1));
    cmd_tb = cmd;
    cmd_v_tb = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1 cmd_v_tb = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_v_w && n < 50);
    check({tag, "_resp_v"}, MW'(resp_v_w), MW'(1));
    check({tag, "_latency"}, MW'(n), MW'(lat));
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check({tag, "_resp"}, resp_w, e);
    held = resp_w;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_stable"}, resp_w, held);
      check({tag, "_hold_ready"}, MW'({ready_w, resp_v_w}), MW'(2'b01));
    end
    yumi_tb = 1'b1;
    @(posedge clk);
    #1 yumi_tb = 1'b0;
    @(negedge clk);
    check({tag, "_post_yumi"}, MW'({ready_w, resp_v_w}), MW'(2'b10));
  endtask

  logic [BW-1:0] pat_a, pat_p, pat_p_exp, pat_c, uc_data;
  int rose;

  initial begin
    for (int i = 0; i < 16; i++) begin
      pat_a[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
      pat_p[32*i +: 32] = 32'h1234_0000 + 32'(i * 3);
      pat_c[32*i +: 32] = 32'hC0DE_0000 ^ 32'(i * 7);
    end
    pat_p_exp = pat_p;
    pat_p_exp[64 +: 64] = 64'hDEAD_BEEF_CAFE_F00D;
    uc_data = {{448{1'b1}}, 64'hDEAD_BEEF_CAFE_F00D};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ready", MW'(if4.mem_cmd_ready), MW'(0));
    check("reset_resp_v", MW'(if4.mem_resp_v), MW'(0));
    check("reset_resp", if4.mem_resp, '0);
    reset = 1'b0;
    @(negedge clk);
    check("first_cycle_ready", MW'(if4.mem_cmd_ready), MW'(1));

    // Full-block write then read at another offset in the same block
    txn("wb_a", mk(T_WB, 40'h80, 3'd6, 16'h0001, pat_a), mk(T_WB, 40'h80, 3'd6, 16'h0001, '0), 5, 0);
    txn("rd_a", mk(T_RD, 40'h9C, 3'd6, 16'h0002, '0), mk(T_RD, 40'h9C, 3'd6, 16'h0002, pat_a), 5, 10);

    // Uncached write/read inside a known block
    txn("wb_p", mk(T_WB, 40'h100, 3'd6, 16'h0003, pat_p), mk(T_WB, 40'h100, 3'd6, 16'h0003, '0), 5, 0);
    txn("uc_wr", mk(T_UC_WR, 40'h108, 3'd3, 16'h0004, uc_data), mk(T_UC_WR, 40'h108, 3'd3, 16'h0004, '0), 5, 0);
    txn("uc_rd2", mk(T_UC_RD, 40'h10A, 3'd1, 16'h0005, '0), mk(T_UC_RD, 40'h10A, 3'd1, 16'h0005, BW'(64'hCAFE)), 5, 0);
    txn("uc_rd_clamp", mk(T_UC_RD, 40'h108, 3'd7, 16'h0006, '0),
        mk(T_UC_RD, 40'h108, 3'd7, 16'h0006, BW'(64'hDEAD_BEEF_CAFE_F00D)), 5, 0);
    txn("uc_rd1", mk(T_UC_RD, 40'h10F, 3'd0, 16'h0007, '0), mk(T_UC_RD, 40'h10F, 3'd0, 16'h0007, BW'(8'hDE)), 5, 0);
    txn("rd_p", mk(T_RD, 40'h100, 3'd6, 16'h0008, '0), mk(T_RD, 40'h100, 3'd6, 16'h0008, pat_p_exp), 5, 0);

    // Address wrap: 64 blocks of 64 bytes, so 0x1000 aliases block 0
    txn("wb_11", mk(T_WB, 40'h0, 3'd6, 16'h0009, BW'(8'h11)), mk(T_WB, 40'h0, 3'd6, 16'h0009, '0), 5, 0);
    txn("wb_22", mk(T_WB, 40'h1000, 3'd6, 16'h000A, BW'(8'h22)), mk(T_WB, 40'h1000, 3'd6, 16'h000A, '0), 5, 0);
    txn("rd_wrap", mk(T_RD, 40'h0, 3'd6, 16'h000B, '0), mk(T_RD, 40'h0, 3'd6, 16'h000B, BW'(8'h22)), 5, 0);

    // Reset two cycles after accepting a read drops the response
    @(negedge clk);
    cmd_tb = mk(T_RD, 40'h80, 3'd6, 16'h000C, '0);
    cmd_v_tb = 1'b1;
    @(posedge clk);
    #1 cmd_v_tb = 1'b0;
    rose = 0;
    repeat (2) begin @(negedge clk); if (if4.mem_resp_v) rose++; end
    reset = 1'b1;
    @(negedge clk);
    check("midreset_resp_v", MW'(if4.mem_resp_v), MW'(0));
    check("midreset_ready", MW'(if4.mem_cmd_ready), MW'(0));
    reset = 1'b0;
    @(negedge clk);
    check("postreset_ready", MW'(if4.mem_cmd_ready), MW'(1));
    repeat (10) begin @(negedge clk); if (if4.mem_resp_v) rose++; end
    check("dropped_resp_never_rises", MW'(rose), MW'(0));
    txn("rd_after_reset", mk(T_RD, 40'h80, 3'd6, 16'h000D, '0), mk(T_RD, 40'h80, 3'd6, 16'h000D, pat_a), 5, 0);

    // Zero-latency build
    sel = 1'b1;
    txn("d0_wb", mk(T_WB, 40'h40, 3'd6, 16'hBEEF, pat_c), mk(T_WB, 40'h40, 3'd6, 16'hBEEF, '0), 1, 0);
    txn("d0_rd", mk(T_RD, 40'h44, 3'd5, 16'h5A5A, '0), mk(T_RD, 40'h44, 3'd5, 16'h5A5A, pat_c), 1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
